// File: rtl/core_pkg.sv
// Shared definitions for the RV32I pipeline scheduler: write-back source
// encodings, operand-forwarding select encodings and the shadow-entry type.
// Pure declarations; no timing and no flow control.
package core_pkg;

    // Write-back source select as produced by the decoder
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_DRAM = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_EXT  = 2'b11;

    // Operand source select driven to the EX-stage operand muxes
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    // Destination info tracked for one in-flight pipeline stage
    typedef struct packed {
        logic       v;   // stage holds a real instruction
        logic [4:0] wr;  // destination register
        logic       we;  // instruction writes the register file
        logic       ld;  // result comes from data memory (load)
    } shadow_t;

    localparam shadow_t SHADOW_NONE = '0;

    // True when the stage will write register rs
    function automatic logic shadow_hit(input shadow_t e, input logic [4:0] rs);
        return e.v && e.we && (e.wr == rs);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Operand source select for one source register (EX > MEM > WB > RF).
// Latency: purely combinational.
// Backpressure: none; a load match in EX is reported instead of forwarded.
//
// Ports:
//   i_rs, i_rs_used      source register and whether the instruction reads it
//   i_ex, i_mem, i_wb    shadow entries for the three downstream stages
//   o_sel                2-bit operand source select
//   o_ex_ld_hit          the operand depends on a load still in EX
module hazard_fwd_sel
    import core_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic       i_rs_used,
    input  shadow_t    i_ex,
    input  shadow_t    i_mem,
    input  shadow_t    i_wb,
    output logic [1:0] o_sel,
    output logic       o_ex_ld_hit
);

    logic w_chk;
    logic w_unused_ld;

    // x0 is hard-wired zero: never forwarded, never a hazard
    assign w_chk = i_rs_used && (i_rs != 5'd0);

    // Load flags of MEM/WB are irrelevant here: data is available by then
    assign w_unused_ld = i_mem.ld ^ i_wb.ld;

    always_comb begin
        o_sel       = FWD_RF;
        o_ex_ld_hit = 1'b0;
        if (w_chk) begin
            if (shadow_hit(i_ex, i_rs)) begin
                // Load data is not ready in EX; the newest producer is the
                // load, so older MEM/WB copies must not be picked either
                if (i_ex.ld) begin
                    o_ex_ld_hit = 1'b1;
                end else begin
                    o_sel = FWD_EX;
                end
            end else if (shadow_hit(i_mem, i_rs)) begin
                o_sel = FWD_MEM;
            end else if (shadow_hit(i_wb, i_rs)) begin
                o_sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline scheduler: stall/flush/forwarding control for the 5-stage RV32I core.
// Latency: outputs combinational from inputs + shadow state; shadow updates next edge.
// Backpressure: load-use holds PC and IF/ID for LOAD_STALL cycles; redirect overrides it.
//
// Ports:
//   clk, rst_n                 core clock, synchronous active-high reset
//   id_*                       register-use and write-back controls of the ID instruction
//   ex_br_taken                EX redirect (taken branch/jump)
//   pc_stall, ifid_stall       hold PC / IF-ID latch
//   ifid_flush, idex_flush     clear IF-ID / insert bubble into ID-EX
//   fwd_a_sel, fwd_b_sel       operand sources for rs1 / rs2
//   stall_cnt, flush_cnt       load-use stall cycles / redirect events
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int LOAD_STALL = 1,   // legal range 1..3
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_wr,
    input  logic             id_rf_we,
    input  logic [1:0]       id_rf_wesl,
    input  logic             ex_br_taken,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] LD_INIT = 2'(LOAD_STALL - 1);

    shadow_t          r_ex;
    shadow_t          r_mem;
    shadow_t          r_wb;
    logic [1:0]       r_ld_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    shadow_t          w_id_entry;
    logic [1:0]       w_a_sel;
    logic [1:0]       w_b_sel;
    logic             w_a_ld_hit;
    logic             w_b_ld_hit;
    logic             w_hz;
    logic             w_stall;

    assign w_id_entry = '{v:  id_valid,
                          wr: id_wr,
                          we: id_rf_we,
                          ld: (id_rf_wesl == WB_DRAM)};

    hazard_fwd_sel u_fwd_a (
        .i_rs        (id_rs1),
        .i_rs_used   (id_rs1_used),
        .i_ex        (r_ex),
        .i_mem       (r_mem),
        .i_wb        (r_wb),
        .o_sel       (w_a_sel),
        .o_ex_ld_hit (w_a_ld_hit)
    );

    hazard_fwd_sel u_fwd_b (
        .i_rs        (id_rs2),
        .i_rs_used   (id_rs2_used),
        .i_ex        (r_ex),
        .i_mem       (r_mem),
        .i_wb        (r_wb),
        .o_sel       (w_b_sel),
        .o_ex_ld_hit (w_b_ld_hit)
    );

    // A bubble in ID never stalls even if its fields alias a load target
    assign w_hz    = id_valid && (w_a_ld_hit || w_b_ld_hit);
    // Remaining cycles of a multi-cycle stall run even after the hazard clears
    assign w_stall = w_hz || (r_ld_cnt != 2'd0);

    always_comb begin
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        fwd_a_sel  = FWD_RF;
        fwd_b_sel  = FWD_RF;
        if (!rst_n) begin
            fwd_a_sel = w_a_sel;
            fwd_b_sel = w_b_sel;
            // Redirect wins: the stalled instruction is on the wrong path
            if (ex_br_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (w_stall) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_ex        <= SHADOW_NONE;
            r_mem       <= SHADOW_NONE;
            r_wb        <= SHADOW_NONE;
            r_ld_cnt    <= 2'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            // The EX instruction always advances; a redirecting branch completes
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= idex_flush ? SHADOW_NONE : w_id_entry;

            if (ex_br_taken) begin
                r_ld_cnt <= 2'd0;
            end else if (r_ld_cnt != 2'd0) begin
                r_ld_cnt <= r_ld_cnt - 2'd1;
            end else if (w_hz) begin
                r_ld_cnt <= LD_INIT;
            end

            if (w_stall && !ex_br_taken) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (ex_br_taken) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    import core_pkg::*;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_wr;
    logic       id_rs1_used, id_rs2_used, id_rf_we;
    logic [1:0] id_rf_wesl;
    logic       ex_br_taken;

    // Instance with LOAD_STALL = 1
    logic        pc_stall1, ifid_stall1, ifid_flush1, idex_flush1;
    logic [1:0]  fwd_a1, fwd_b1;
    logic [31:0] stall_cnt1, flush_cnt1;
    // Instance with LOAD_STALL = 3
    logic        pc_stall3, ifid_stall3, ifid_flush3, idex_flush3;
    logic [1:0]  fwd_a3, fwd_b3;
    logic [31:0] stall_cnt3, flush_cnt3;

    hazard_ctrl #(.LOAD_STALL(1), .CNT_W(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_wr(id_wr), .id_rf_we(id_rf_we), .id_rf_wesl(id_rf_wesl),
        .ex_br_taken(ex_br_taken),
        .pc_stall(pc_stall1), .ifid_stall(ifid_stall1),
        .ifid_flush(ifid_flush1), .idex_flush(idex_flush1),
        .fwd_a_sel(fwd_a1), .fwd_b_sel(fwd_b1),
        .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
    );

    hazard_ctrl #(.LOAD_STALL(3), .CNT_W(32)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_wr(id_wr), .id_rf_we(id_rf_we), .id_rf_wesl(id_rf_wesl),
        .ex_br_taken(ex_br_taken),
        .pc_stall(pc_stall3), .ifid_stall(ifid_stall3),
        .ifid_flush(ifid_flush3), .idex_flush(idex_flush3),
        .fwd_a_sel(fwd_a3), .fwd_b_sel(fwd_b3),
        .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] wr,
                         input logic we, input logic [1:0] wesl);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rs1_used = u1;
        id_rs2_used = u2;
        id_wr       = wr;
        id_rf_we    = we;
        id_rf_wesl  = wesl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, WB_ALU);
    endtask

    // Inputs change just after a falling edge; checks run 1 time unit later
    task automatic drain();
        idle();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b1;
        ex_br_taken = 1'b1;
        // A would-be forwarding candidate while in reset
        drive(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, WB_DRAM);

        // ---------------- reset state ----------------
        @(negedge clk);
        #1;
        chk("rst_ifid_flush", 32'(ifid_flush1), 32'd0);
        chk("rst_idex_flush", 32'(idex_flush3), 32'd0);
        chk("rst_pc_stall",   32'(pc_stall1),   32'd0);
        chk("rst_fwd_a",      32'(fwd_a1),      32'd0);
        chk("rst_stall_cnt",  stall_cnt1,       32'd0);
        chk("rst_flush_cnt",  flush_cnt3,       32'd0);
        @(negedge clk);
        rst_n       = 1'b0;
        ex_br_taken = 1'b0;

        // ---------------- ALU chain ----------------
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, WB_ALU);   // add x5,x1,x2
        #1;
        chk("alu0_pc_stall", 32'(pc_stall1), 32'd0);
        chk("alu0_fwd_a",    32'(fwd_a1),    32'd0);
        @(negedge clk);
        drive(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, WB_ALU);   // sub x6,x5,x3
        #1;
        chk("alu1_fwd_a",      32'(fwd_a1),      32'd1);
        chk("alu1_fwd_b",      32'(fwd_b1),      32'd0);
        chk("alu1_pc_stall",   32'(pc_stall1),   32'd0);
        chk("alu1_idex_flush", 32'(idex_flush1), 32'd0);
        chk("alu1_fwd_a_ls3",  32'(fwd_a3),      32'd1);
        @(negedge clk);
        drive(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd10, 1'b1, WB_ALU);  // add x10,x5,x6
        #1;
        chk("alu2_fwd_a_mem", 32'(fwd_a1), 32'd2);
        chk("alu2_fwd_b_ex",  32'(fwd_b1), 32'd1);
        @(negedge clk);
        drain();

        // ---------------- load-use, both LOAD_STALL values ----------------
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, WB_DRAM);  // lw x7,0(x1)
        #1;
        chk("lw_pc_stall", 32'(pc_stall1), 32'd0);
        @(negedge clk);
        drive(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, WB_ALU);   // add x8,x7,x7
        #1;
        chk("lu_c0_pc_stall1",   32'(pc_stall1),   32'd1);
        chk("lu_c0_ifid_stall1", 32'(ifid_stall1), 32'd1);
        chk("lu_c0_idex_flush1", 32'(idex_flush1), 32'd1);
        chk("lu_c0_ifid_flush1", 32'(ifid_flush1), 32'd0);
        chk("lu_c0_pc_stall3",   32'(pc_stall3),   32'd1);
        @(negedge clk);
        #1;
        chk("lu_c1_pc_stall1",  32'(pc_stall1), 32'd0);
        chk("lu_c1_fwd_a1",     32'(fwd_a1),    32'd2);
        chk("lu_c1_fwd_b1",     32'(fwd_b1),    32'd2);
        chk("lu_c1_stall_cnt1", stall_cnt1,     32'd1);
        chk("lu_c1_pc_stall3",  32'(pc_stall3), 32'd1);
        @(negedge clk);
        #1;
        chk("lu_c2_pc_stall1",   32'(pc_stall1),   32'd0);
        chk("lu_c2_fwd_a1_wb",   32'(fwd_a1),      32'd3);
        chk("lu_c2_pc_stall3",   32'(pc_stall3),   32'd1);
        chk("lu_c2_idex_flush3", 32'(idex_flush3), 32'd1);
        @(negedge clk);
        #1;
        chk("lu_c3_pc_stall3",  32'(pc_stall3), 32'd0);
        chk("lu_c3_fwd_a3",     32'(fwd_a3),    32'd0);
        chk("lu_c3_fwd_b3",     32'(fwd_b3),    32'd0);
        chk("lu_c3_stall_cnt3", stall_cnt3,     32'd3);
        chk("lu_c3_stall_cnt1", stall_cnt1,     32'd1);
        @(negedge clk);
        drain();

        // ---------------- x0 destination ----------------
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, WB_ALU);   // addi x0,x1,1
        @(negedge clk);
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, WB_ALU);   // add x9,x0,x0
        #1;
        chk("x0_fwd_a",    32'(fwd_a1),    32'd0);
        chk("x0_fwd_b",    32'(fwd_b1),    32'd0);
        chk("x0_pc_stall", 32'(pc_stall1), 32'd0);
        @(negedge clk);
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, WB_DRAM);  // lw x0,0(x1)
        @(negedge clk);
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, WB_ALU);   // add x9,x0,x0
        #1;
        chk("x0ld_pc_stall1", 32'(pc_stall1), 32'd0);
        chk("x0ld_pc_stall3", 32'(pc_stall3), 32'd0);
        @(negedge clk);
        drain();

        // ---------------- redirect during a load-use stall ----------------
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, WB_DRAM);  // lw x7
        @(negedge clk);
        drive(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, WB_ALU);   // add x8,x7,x7
        #1;
        chk("br_c0_pc_stall3", 32'(pc_stall3), 32'd1);
        @(negedge clk);
        ex_br_taken = 1'b1;
        #1;
        chk("br_c1_ifid_flush3", 32'(ifid_flush3), 32'd1);
        chk("br_c1_idex_flush3", 32'(idex_flush3), 32'd1);
        chk("br_c1_pc_stall3",   32'(pc_stall3),   32'd0);
        chk("br_c1_ifid_stall3", 32'(ifid_stall3), 32'd0);
        @(negedge clk);
        ex_br_taken = 1'b0;
        #1;
        chk("br_c2_pc_stall3",   32'(pc_stall3), 32'd0);
        chk("br_c2_flush_cnt3",  flush_cnt3,     32'd1);
        chk("br_c2_stall_cnt3",  stall_cnt3,     32'd1);
        chk("br_c2_fwd_a3_wb",   32'(fwd_a3),    32'd3);
        @(negedge clk);
        drain();

        // ---------------- reset in the middle of a stall ----------------
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, WB_DRAM);  // lw x7
        @(negedge clk);
        drive(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, WB_ALU);   // add x8,x7,x7
        #1;
        chk("rs_c0_pc_stall3", 32'(pc_stall3), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rs_c1_pc_stall3",   32'(pc_stall3),   32'd0);
        chk("rs_c1_idex_flush3", 32'(idex_flush3), 32'd0);
        chk("rs_c1_fwd_a3",      32'(fwd_a3),      32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rs_c2_pc_stall3",   32'(pc_stall3),   32'd0);
        chk("rs_c2_idex_flush3", 32'(idex_flush3), 32'd0);
        chk("rs_c2_fwd_a3",      32'(fwd_a3),      32'd0);
        chk("rs_c2_fwd_b3",      32'(fwd_b3),      32'd0);
        chk("rs_c2_stall_cnt3",  stall_cnt3,       32'd0);
        chk("rs_c2_flush_cnt3",  flush_cnt3,       32'd0);
        @(negedge clk);
        #1;
        chk("rs_c3_pc_stall3", 32'(pc_stall3), 32'd0);
        @(negedge clk);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
